// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode constants, bubble encoding and fetch FSM states
`timescale 1ns/1ps
package riscv_pkg;

    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    // addi x0,x0,0 - what decode sees when fetch has nothing real to offer
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ         = 2'd0,
        WAIT        = 2'd1,
        BRANCH_WAIT = 2'd2,
        RESUME      = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry holding register for a response that lands while frozen
//
// Ports:
//   clk, rst_h        clock, asynchronous active-high reset
//   load              capture load_data/load_pc (wins over drain)
//   load_data/load_pc instruction word and the PC it was fetched from
//   drain             entry consumed this edge
//   flush             discard the entry (highest priority after reset)
//   valid/data/pc     held entry
`timescale 1ns/1ps
module fetch_skid_buffer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_h,
    input  logic            load,
    input  logic [31:0]     load_data,
    input  logic [XLEN-1:0] load_pc,
    input  logic            drain,
    input  logic            flush,
    output logic            valid,
    output logic [31:0]     data,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: owns the PC, talks req/gnt/rvalid to imem, feeds decode
//
// Ports:
//   clk, rst_h              clock, asynchronous active-high reset
//   stop                    global freeze shared with decode
//   request_stop_pipeline   branch detector: control-flow instr in decode or stall window active
//   branch_resolved         one-cycle pulse from execute, qualified by branch_taken/branch_target
//   imem_req/imem_addr      word request at the current PC
//   imem_gnt/imem_rvalid    request accepted / read data valid (imem_rdata)
//   instr/instr_pc          instruction presented to decode and its PC
//   instr_valid             instr is real; otherwise instr holds the bubble encoding
`timescale 1ns/1ps
module instruction_fetch #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_h,
    input  logic            stop,
    input  logic            request_stop_pipeline,
    input  logic            branch_resolved,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid
);
    import riscv_pkg::*;

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next, pc_plus4;

    logic            out_load;
    logic [31:0]     out_data;
    logic [XLEN-1:0] out_pc;

    // branch outcome that arrived while frozen, applied on the first unfrozen edge
    logic            pend_valid, pend_taken;
    logic [XLEN-1:0] pend_target;

    logic            resolve, res_taken;
    logic [XLEN-1:0] res_target;

    logic            skid_valid, skid_load, skid_drain, skid_flush;
    logic [31:0]     skid_data;
    logic [XLEN-1:0] skid_pc;

    assign imem_req  = (state == REQ) && !stop && !request_stop_pipeline;
    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(4);

    // Only WAIT has an outstanding request, so only WAIT can receive a response.
    assign skid_load  = stop && (state == WAIT) && imem_rvalid;
    assign skid_drain = !stop && (state == WAIT);
    assign skid_flush = (state != WAIT);

    fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
        .clk       (clk),
        .rst_h     (rst_h),
        .load      (skid_load),
        .load_data (imem_rdata),
        .load_pc   (pc),
        .drain     (skid_drain),
        .flush     (skid_flush),
        .valid     (skid_valid),
        .data      (skid_data),
        .pc        (skid_pc)
    );

    assign resolve    = pend_valid || branch_resolved;
    assign res_taken  = pend_valid ? pend_taken  : branch_taken;
    assign res_target = pend_valid ? pend_target : branch_target;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        out_load   = 1'b0;
        out_data   = imem_rdata;
        out_pc     = pc;
        case (state)
            REQ: begin
                // The control-flow instruction is consumed here; pc already points past it.
                if (instr_valid && request_stop_pipeline) begin
                    state_next = BRANCH_WAIT;
                end else if (imem_req && imem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (skid_valid) begin
                    out_load   = 1'b1;
                    out_data   = skid_data;
                    out_pc     = skid_pc;
                    pc_next    = pc_plus4;
                    state_next = REQ;
                end else if (imem_rvalid) begin
                    out_load   = 1'b1;
                    pc_next    = pc_plus4;
                    state_next = REQ;
                end
            end
            BRANCH_WAIT: begin
                if (resolve) begin
                    pc_next    = res_taken ? (res_target & ~XLEN'(3)) : pc;
                    state_next = RESUME;
                end
            end
            RESUME: begin
                if (!request_stop_pipeline) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            state       <= REQ;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            pend_valid  <= 1'b0;
            pend_taken  <= 1'b0;
            pend_target <= '0;
        end else if (!stop) begin
            state      <= state_next;
            pc         <= pc_next;
            pend_valid <= 1'b0;
            // Single-shot output: a real instruction lives for one unfrozen cycle only.
            if (out_load) begin
                instr       <= out_data;
                instr_pc    <= out_pc;
                instr_valid <= 1'b1;
            end else if (instr_valid) begin
                instr       <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end else if ((state == BRANCH_WAIT) && branch_resolved) begin
            pend_valid  <= 1'b1;
            pend_taken  <= branch_taken;
            pend_target <= branch_target;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized scoreboard bench for instruction_fetch
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_h;
    logic        stop;
    logic        rsp;
    logic        branch_resolved;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    logic        mem_en, mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        man_gnt, man_rvalid;
    logic [31:0] man_rdata;
    bit          det_en, stop_en, mon_en;

    assign imem_gnt    = mem_en ? mem_gnt    : man_gnt;
    assign imem_rvalid = mem_en ? mem_rvalid : man_rvalid;
    assign imem_rdata  = mem_en ? mem_rdata  : man_rdata;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic taken; logic [31:0] target; } dec_t;
    exp_t exp_q[$];
    dec_t dec_q[$];

    instruction_fetch #(
        .XLEN(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)
    ) dut (
        .clk                   (clk),
        .rst_h                 (rst_h),
        .stop                  (stop),
        .request_stop_pipeline (rsp),
        .branch_resolved       (branch_resolved),
        .branch_taken          (branch_taken),
        .branch_target         (branch_target),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_gnt              (imem_gnt),
        .imem_rvalid           (imem_rvalid),
        .imem_rdata            (imem_rdata),
        .instr                 (instr),
        .instr_pc              (instr_pc),
        .instr_valid           (instr_valid)
    );

    always #5 clk = ~clk;

    // Program image: every 16th word is control flow, the rest are addi-style words.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] opc;
        if (a[5:2] == 4'd5) begin
            case (a[8:7])
                2'd1:    opc = 7'b1100011;
                2'd2:    opc = 7'b1100111;
                default: opc = 7'b1101111;
            endcase
            return {a[31:7] ^ 25'h0000ABC, opc};
        end
        return {a[26:2] ^ 25'h1A5A5A5, 7'b0010011};
    endfunction

    function automatic bit is_cf(input logic [31:0] w);
        return (w[6:0] == 7'b1101111) || (w[6:0] == 7'b1100111) || (w[6:0] == 7'b1100011);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Global freeze: random single-cycle and short back-to-back stalls.
    initial begin
        stop = 1'b0;
        forever begin
            @(negedge clk);
            stop = stop_en ? ($urandom % 4 == 0) : 1'b0;
        end
    end

    // Memory: random grant, response 1..3 cycles after acceptance, ignores stop.
    logic [31:0] m_addr;
    int          m_cnt;
    bit          m_outst;
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        m_outst = 1'b0; m_cnt = 0; m_addr = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rst_h) begin
                m_outst = 1'b0;
            end else if (m_outst) begin
                if (m_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(m_addr);
                    m_outst    = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            mem_gnt = ($urandom % 4 != 0);
            #1;
            if (mem_en && !rst_h && imem_req && imem_gnt) begin
                check("one_outstanding", {31'b0, m_outst}, 32'h0);
                m_outst = 1'b1;
                m_addr  = imem_addr;
                m_cnt   = $urandom % 3;
            end
        end
    end

    // Branch detector / execute: holds the pipeline while a control-flow instr is in decode,
    // then resolves it after a random delay and keeps the stall a little longer.
    int   d_phase, d_res_cnt, d_tail;
    bit   d_seen;
    dec_t d_cur;
    initial begin
        rsp = 1'b0; branch_resolved = 1'b0; branch_taken = 1'b0; branch_target = '0;
        d_phase = 0; d_seen = 1'b0; d_res_cnt = 0; d_tail = 0;
        forever begin
            @(negedge clk);
            branch_resolved = 1'b0;
            if (!det_en || rst_h) begin
                rsp = 1'b0; d_phase = 0; d_seen = 1'b0;
            end else if (d_phase == 0) begin
                if (instr_valid && is_cf(instr)) begin
                    rsp = 1'b1; d_seen = 1'b1;
                end else if (d_seen && !instr_valid) begin
                    d_seen = 1'b0;
                    if (dec_q.size() > 0) d_cur = dec_q.pop_front();
                    else d_cur = '{taken: 1'b0, target: 32'h0};
                    d_res_cnt = $urandom % 3;
                    d_phase = 1;
                end
            end else if (d_phase == 1) begin
                if (d_res_cnt == 0) begin
                    branch_resolved = 1'b1;
                    branch_taken    = d_cur.taken;
                    branch_target   = d_cur.target;
                    d_tail  = $urandom % 3;
                    d_phase = 2;
                end else begin
                    d_res_cnt--;
                end
            end else begin
                if (d_tail == 0) begin
                    rsp = 1'b0; d_phase = 0;
                end else begin
                    d_tail--;
                end
            end
        end
    end

    // Monitor: every unfrozen valid cycle is one presentation, popped off the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && !rst_h) begin
                check("no_req_when_held", {31'b0, imem_req & (rsp | stop)}, 32'h0);
                if (instr_valid && !stop) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_instr", instr_pc, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr", instr, e.data);
                        check("instr_pc", instr_pc, e.pc);
                    end
                end else if (!instr_valid) begin
                    check("bubble", instr, NOP);
                end
            end
        end
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] w;
        dec_t        d;
        int          nbr;
        int          cycles;

        rst_h = 1'b1;
        mem_en = 1'b0; det_en = 1'b0; stop_en = 1'b0; mon_en = 1'b0;
        man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;

        // Reference stream: sequential words, redirected at control flow by the chosen outcome.
        pc = RESET_PC; nbr = 0;
        for (int k = 0; k < 160; k++) begin
            w = mem_word(pc);
            exp_q.push_back('{pc: pc, data: w});
            if (is_cf(w)) begin
                if (nbr == 0) begin
                    d.taken = 1'b0; d.target = 32'h0000_0100;
                end else if (nbr == 1) begin
                    d.taken = 1'b1; d.target = 32'hFFFF_FFFE;
                end else begin
                    d.taken  = ($urandom % 2 == 1);
                    d.target = ($urandom % 6 == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 2047));
                end
                dec_q.push_back(d);
                nbr++;
                pc = d.taken ? (d.target & ~32'h3) : pc + 32'd4;
            end else begin
                pc = pc + 32'd4;
            end
        end

        repeat (3) @(negedge clk);
        #1;
        check("rst_instr", instr, NOP);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h1);
        check("rst_addr", imem_addr, RESET_PC);

        @(negedge clk);
        mem_en = 1'b1; det_en = 1'b1; stop_en = 1'b1; mon_en = 1'b1;
        @(negedge clk);
        rst_h = 1'b0;

        cycles = 0;
        while (exp_q.size() > 4 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
        end
        if (exp_q.size() > 4) begin
            miscompares++;
            $display("FAIL stream_timeout: %0d presentations still outstanding, expected at most 4", exp_q.size());
        end

        @(negedge clk);
        mon_en = 1'b0; det_en = 1'b0; stop_en = 1'b0; mem_en = 1'b0;

        // Reset mid-transaction, then a stale response right after release.
        @(negedge clk);
        rst_h = 1'b1;
        repeat (2) @(negedge clk);
        rst_h   = 1'b0;
        man_gnt = 1'b1;
        @(negedge clk);
        man_gnt = 1'b0;
        #1;
        check("wait_no_req", {31'b0, imem_req}, 32'h0);
        #2;
        rst_h = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, instr_valid}, 32'h0);
        check("async_rst_req", {31'b0, imem_req}, 32'h1);
        check("async_rst_addr", imem_addr, RESET_PC);
        @(negedge clk);
        rst_h      = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        man_rvalid = 1'b0;
        #1;
        check("stale_valid", {31'b0, instr_valid}, 32'h0);
        check("stale_addr", imem_addr, RESET_PC);
        check("stale_req", {31'b0, imem_req}, 32'h1);
        @(negedge clk);
        #1;
        check("stale_valid2", {31'b0, instr_valid}, 32'h0);
        check("stale_instr", instr, NOP);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
